// File: rtl/wfg_wishbone_regbank.sv
`default_nettype none
// ============================================================================
// Module   : wfg_wishbone_regbank
// Purpose  : Wishbone classic-cycle slave holding NREGS 32-bit registers,
//            optionally double-buffered (shadow written by the bus, active
//            loaded from shadow on commit_i).
// Ports    : wb_clk_i / wb_rst_i       clock, async active-high reset
//            wbs_*_i                   Wishbone slave request
//            wbs_ack_o / wbs_err_o     one-cycle response
//            wbs_dat_o                 registered read data (0 unless read ack)
//            commit_i                  shadow -> active transfer pulse
//            regs_q_o                  active register values, reg n at slice n
//            wr_pulse_o                one-cycle pulse per register write
// Revision : 1.0 - initial release
// ============================================================================
module wfg_wishbone_regbank #(
  parameter int                      BUSW      = 32,
  parameter int                      NREGS     = 8,
  parameter logic [BUSW-1:0]         BASE_ADDR = 'h010,
  parameter logic [NREGS-1:0]        RO_MASK   = '0,
  parameter logic [NREGS*BUSW-1:0]   RESET_VAL = '0,
  parameter bit                      SHADOW    = 1'b1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [BUSW/8-1:0]       wbs_sel_i,
  input  logic [BUSW-1:0]         wbs_dat_i,
  input  logic [BUSW-1:0]         wbs_adr_i,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  output logic [BUSW-1:0]         wbs_dat_o,
  input  logic                    commit_i,
  output logic [NREGS*BUSW-1:0]   regs_q_o,
  output logic [NREGS-1:0]        wr_pulse_o
);

  localparam int C_NBYTES = BUSW / 8;
  localparam int C_IDXW   = (NREGS > 1) ? $clog2(NREGS) : 1;
  // Static configuration error: an illegal build answers every access with err.
  localparam bit C_CFG_ERR = (BUSW != 32) || (NREGS < 1) || (NREGS > 64);

  logic                  w_req;
  logic                  w_hit;
  logic                  w_ro;
  logic                  w_err_resp;
  logic                  w_ok;
  logic [BUSW-1:0]       w_word;
  logic [C_IDXW-1:0]     w_idx;
  logic [BUSW-1:0]       w_rd_data;
  logic [NREGS-1:0]      w_wr;
  logic [NREGS*BUSW-1:0] w_shadow_flat;
  logic [NREGS*BUSW-1:0] w_active_flat;

  logic                  r_ack;
  logic                  r_err;
  logic [BUSW-1:0]       r_dat;
  logic [NREGS-1:0]      r_wr_pulse;

  function automatic logic [BUSW-1:0] f_merge(input logic [BUSW-1:0]     old_val,
                                              input logic [BUSW-1:0]     new_val,
                                              input logic [C_NBYTES-1:0] sel);
    logic [BUSW-1:0] res;
    res = old_val;
    for (int k = 0; k < C_NBYTES; k++) begin
      if (sel[k]) res[k*8 +: 8] = new_val[k*8 +: 8];
    end
    return res;
  endfunction

  // Gating with the pending response makes a held strobe alternate
  // request / response, giving one response every two cycles.
  assign w_req  = wbs_stb_i & wbs_cyc_i & ~r_ack & ~r_err;

  // Addresses below BASE_ADDR wrap to a huge word index and miss naturally.
  assign w_word = (wbs_adr_i - BASE_ADDR) >> 2;
  assign w_hit  = (wbs_adr_i[1:0] == 2'b00) && (w_word < BUSW'(NREGS));
  assign w_idx  = w_word[C_IDXW-1:0];

  // Read mux and RO lookup. Reads come from the shadow copy: with SHADOW=0
  // the shadow is the active register, so this serves both builds.
  always_comb begin
    w_rd_data = '0;
    w_ro      = 1'b0;
    for (int n = 0; n < NREGS; n++) begin
      if (w_idx == C_IDXW'(n)) begin
        w_rd_data = w_shadow_flat[n*BUSW +: BUSW];
        w_ro      = RO_MASK[n];
      end
    end
  end

  assign w_err_resp = w_req & (C_CFG_ERR | ~w_hit | (wbs_we_i & w_ro));
  assign w_ok       = w_req & ~w_err_resp;

  for (genvar n = 0; n < NREGS; n++) begin : g_reg
    localparam logic [BUSW-1:0] C_RST = RESET_VAL[n*BUSW +: BUSW];

    assign w_wr[n] = w_ok & wbs_we_i & (w_idx == C_IDXW'(n));

    if (RO_MASK[n]) begin : g_ro
      // Read-only registers are their reset value, forever.
      assign w_shadow_flat[n*BUSW +: BUSW] = C_RST;
      assign w_active_flat[n*BUSW +: BUSW] = C_RST;
    end else begin : g_rw
      logic [BUSW-1:0] r_shadow;

      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)     r_shadow <= C_RST;
        else if (w_wr[n]) r_shadow <= f_merge(r_shadow, wbs_dat_i, wbs_sel_i);
      end

      assign w_shadow_flat[n*BUSW +: BUSW] = r_shadow;

      if (SHADOW) begin : g_dbl
        logic [BUSW-1:0] r_active;
        // Commit samples the pre-write shadow, so a same-cycle write lands
        // in the shadow only and needs a further commit to go live.
        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
          if (wb_rst_i)      r_active <= C_RST;
          else if (commit_i) r_active <= r_shadow;
        end
        assign w_active_flat[n*BUSW +: BUSW] = r_active;
      end else begin : g_direct
        assign w_active_flat[n*BUSW +: BUSW] = r_shadow;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat      <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_ack      <= w_ok;
      r_err      <= w_err_resp;
      r_dat      <= (w_ok & ~wbs_we_i) ? w_rd_data : '0;
      r_wr_pulse <= w_wr;
    end
  end

  assign wbs_ack_o  = r_ack;
  assign wbs_err_o  = r_err;
  assign wbs_dat_o  = r_dat;
  assign wr_pulse_o = r_wr_pulse;
  assign regs_q_o   = w_active_flat;

endmodule
`default_nettype wire

// File: tb/tb_wfg_wishbone_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_wfg_wishbone_regbank
// Purpose  : Self-checking bench for wfg_wishbone_regbank. A register-level
//            model (shadow/active arrays) predicts every response.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wfg_wishbone_regbank;

  localparam int          NREGS = 8;
  localparam logic [31:0] BASE  = 32'h010;
  localparam logic [7:0]  ROM   = 8'h80;
  localparam logic [255:0] RV   = {32'hDEADBEEF, 32'h0, 32'h0, 32'h0,
                                   32'h0, 32'h0, 32'h000000A5, 32'h0};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stb = 1'b0;
  logic         cyc = 1'b0;
  logic         we  = 1'b0;
  logic [3:0]   sel = '0;
  logic [31:0]  dat_i = '0;
  logic [31:0]  adr = '0;
  logic         ack;
  logic         err;
  logic [31:0]  dat_o;
  logic         commit = 1'b0;
  logic [255:0] regs_q;
  logic [7:0]   wr_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_sh [NREGS];
  logic [31:0] m_ac [NREGS];

  wfg_wishbone_regbank #(
    .BUSW      (32),
    .NREGS     (NREGS),
    .BASE_ADDR (BASE),
    .RO_MASK   (ROM),
    .RESET_VAL (RV),
    .SHADOW    (1'b1)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_dat_i  (dat_i),
    .wbs_adr_i  (adr),
    .wbs_ack_o  (ack),
    .wbs_err_o  (err),
    .wbs_dat_o  (dat_o),
    .commit_i   (commit),
    .regs_q_o   (regs_q),
    .wr_pulse_o (wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] m_pack();
    logic [255:0] r;
    for (int n = 0; n < NREGS; n++) r[n*32 +: 32] = m_ac[n];
    return r;
  endfunction

  function automatic void m_reset();
    for (int n = 0; n < NREGS; n++) begin
      m_sh[n] = RV[n*32 +: 32];
      m_ac[n] = RV[n*32 +: 32];
    end
  endfunction

  function automatic void m_commit();
    for (int n = 0; n < NREGS; n++) if (!ROM[n]) m_ac[n] = m_sh[n];
  endfunction

  // One bus transfer, optionally with a simultaneous commit pulse.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic cmt);
    logic        hit;
    logic        eerr;
    int          n;
    logic [31:0] edat;
    logic [7:0]  epulse;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_i = d; commit = cmt;
    hit    = (a[1:0] == 2'b00) && (a >= BASE) && (((a - BASE) >> 2) < NREGS);
    n      = hit ? int'((a - BASE) >> 2) : 0;
    eerr   = !hit || (w && ROM[n]);
    edat   = (!eerr && !w) ? m_sh[n] : 32'h0;
    epulse = (!eerr && w) ? 8'(1 << n) : 8'h0;
    if (cmt) m_commit();
    if (!eerr && w)
      for (int k = 0; k < 4; k++) if (s[k]) m_sh[n][k*8 +: 8] = d[k*8 +: 8];
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; commit = 1'b0;
    check_eq("ack", 256'(ack), 256'(!eerr));
    check_eq("err", 256'(err), 256'(eerr));
    check_eq("rdata", 256'(dat_o), 256'(edat));
    check_eq("wr_pulse", 256'(wr_pulse), 256'(epulse));
    check_eq("regs_q", regs_q, m_pack());
    @(posedge clk); #1;
    check_eq("idle_ack", 256'(ack), 256'(0));
    check_eq("idle_err", 256'(err), 256'(0));
    check_eq("idle_rdata", 256'(dat_o), 256'(0));
    check_eq("idle_pulse", 256'(wr_pulse), 256'(0));
  endtask

  task automatic commit_only();
    @(negedge clk);
    commit = 1'b1;
    m_commit();
    @(posedge clk); #1;
    commit = 1'b0;
    check_eq("commit_regs", regs_q, m_pack());
    check_eq("commit_ack", 256'(ack), 256'(0));
  endtask

  initial begin
    logic [31:0] a;
    int          acks;
    m_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", 256'(ack), 256'(0));
    check_eq("rst_err", 256'(err), 256'(0));
    check_eq("rst_rdata", 256'(dat_o), 256'(0));
    check_eq("rst_pulse", 256'(wr_pulse), 256'(0));
    check_eq("rst_regs", regs_q, RV);
    rst = 1'b0;

    // First-cycle read of register 1 after reset
    xfer(1'b0, BASE + 32'd4, 4'h0, 32'h0, 1'b0);

    // Byte-masked write then commit
    xfer(1'b1, BASE, 4'b0101, 32'h12345678, 1'b0);
    commit_only();
    check_eq("masked_commit", 256'(regs_q[31:0]), 256'(32'h00340078));

    // Illegal accesses: RO, misaligned, past the end
    xfer(1'b1, BASE + 32'd28, 4'hF, 32'h0, 1'b0);
    xfer(1'b1, BASE + 32'd2, 4'hF, 32'hFFFFFFFF, 1'b0);
    xfer(1'b1, BASE + 32'd4 * NREGS, 4'hF, 32'hFFFFFFFF, 1'b0);
    xfer(1'b0, BASE + 32'd28, 4'hF, 32'h0, 1'b0);

    // Commit racing a write
    xfer(1'b1, BASE + 32'd8, 4'hF, 32'h11, 1'b0);
    commit_only();
    xfer(1'b1, BASE + 32'd8, 4'hF, 32'hFF, 1'b1);
    check_eq("race_active_old", 256'(regs_q[95:64]), 256'(32'h11));
    commit_only();
    check_eq("race_active_new", 256'(regs_q[95:64]), 256'(32'hFF));

    // sel == 0 write still acks and pulses
    xfer(1'b1, BASE + 32'd12, 4'h0, 32'hABCDEF01, 1'b0);

    // Held strobe: responses after edges 0, 2, 4 only
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'd4; sel = 4'h0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("held_ack", 256'(ack), 256'(i % 2 == 0));
      check_eq("held_rdata", 256'(dat_o), 256'((i % 2 == 0) ? m_sh[1] : 32'h0));
      if (ack) acks++;
    end
    stb = 1'b0; cyc = 1'b0;
    check_eq("held_ack_count", 256'(acks), 256'(3));
    @(posedge clk); #1;

    // Randomised traffic
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, NREGS - 1));
        3:       a = BASE + 32'(4 * $urandom_range(0, NREGS - 1) + $urandom_range(1, 3));
        4:       a = BASE + 32'(4 * NREGS + 4 * $urandom_range(0, 3));
        default: a = 32'($urandom_range(0, 'h3F));
      endcase
      xfer(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) commit_only();
    end

    // Reset landing on a pending write: no response, registers back to reset
    xfer(1'b1, BASE + 32'd12, 4'hF, 32'hCAFE0000, 1'b1);
    commit_only();
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'd12; sel = 4'hF; dat_i = 32'h1234;
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      stb = 1'b0; cyc = 1'b0;
      check_eq("rstabort_ack", 256'(ack), 256'(0));
      check_eq("rstabort_err", 256'(err), 256'(0));
      check_eq("rstabort_pulse", 256'(wr_pulse), 256'(0));
    end
    m_reset();
    check_eq("rstabort_regs", regs_q, RV);
    rst = 1'b0;
    xfer(1'b0, BASE + 32'd12, 4'h0, 32'h0, 1'b0);
    xfer(1'b0, BASE + 32'd4, 4'h0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wfg_wishbone_regbank.md
WFG_WISHBONE_REGBANK -- requirements
Module: wfg_wishbone_regbank

Interface
REQ-001 SHALL have parameter BUSW, default 32, Wishbone data/address width; legal values are 32 only, and a 1-bit static error is flagged otherwise.
REQ-002 SHALL have parameter NREGS, default 8, number of 32-bit registers; legal range 1..64.
REQ-003 SHALL have parameter BASE_ADDR, default 'h010, byte address of register 0.
REQ-004 SHALL have parameter RO_MASK, default 0, NREGS bits; bit n=1 makes register n read-only.
REQ-005 SHALL have parameter RESET_VAL, default 0, NREGS*BUSW bits; slice n is the reset value of register n.
REQ-006 SHALL have parameter SHADOW, default 1; 1 = double-buffered registers, 0 = writes go directly to outputs.
REQ-007 SHALL have port wb_clk_i  in  1  the single clock, rising edge.
REQ-008 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have Wishbone slave ports wbs_stb_i, wbs_cyc_i, wbs_we_i, all in, 1 bit: classic-cycle strobe, cycle and write enable.
REQ-010 SHALL have Wishbone slave ports wbs_sel_i  in  BUSW/8  byte lanes; wbs_dat_i  in  BUSW  write data; wbs_adr_i  in  BUSW  byte address.
REQ-011 SHALL have port wbs_ack_o  out  1  transfer acknowledge; and port wbs_err_o  out  1  transfer error.
REQ-012 SHALL have port wbs_dat_o  out  BUSW  registered read data.
REQ-013 SHALL have ports commit_i  in  1  shadow-to-active transfer pulse; and regs_q_o  out  NREGS*BUSW  active register values.
REQ-014 SHALL have port wr_pulse_o  out  NREGS  one-cycle pulse per register write.

Function
REQ-015 SHALL decode the address as a hit on register n = (adr-BASE_ADDR)>>2 when adr[1:0]==0 and 0<=n<NREGS.
REQ-016 SHALL handle each request (stb&cyc&~ack&~err) with a single response: exactly one of ack or err is asserted in the following cycle, for one cycle.
REQ-017 SHALL ensure the next request is not seen until one cycle after the response, so a held stb produces one response every 2 cycles.
REQ-018 SHALL respond with err for a miss, a misaligned address, or a write to an RO_MASK register; such an access changes no state and causes no wr_pulse_o.
REQ-019 SHALL perform a write hit on a writable register byte-masked into that register's shadow: byte k is updated iff sel[k]; wr_pulse_o[n] pulses in the ack cycle.
REQ-020 SHALL, with SHADOW=1, give regs_q_o slice n the shadow value one cycle after commit_i; with SHADOW=0, write byte-masked straight to the active register.
REQ-021 SHALL register read data (wbs_dat_o) from the shadow (SHADOW=1) or active register, valid in the ack cycle, and 0 otherwise, including on err cycles.
REQ-022 SHALL give precedence on a simultaneous commit_i and write to register n as follows: active takes the old shadow, and shadow takes the new data.
REQ-023 SHALL ignore wbs_sel_i on reads; a write with sel==0 still acks and pulses wr_pulse_o.
REQ-024 SHALL give RO registers their RESET_VAL permanently; commit_i has no effect on them.

Reset
REQ-025 SHALL, while wb_rst_i=1 and asynchronously, set shadow and active n to RESET_VAL slice n, and set ack=0, err=0, wbs_dat_o=0 and wr_pulse_o=0.
REQ-026 SHALL abort any transfer interrupted by reset with no response; the master must re-issue it.
REQ-027 SHALL accept a new request in the first cycle after reset deassertion.

Verification
REQ-028 SHALL cover: reset, then read at BASE+4 with RESET_VAL slice1='hA5 -> ack at cycle 1 and dat='hA5; err=0.
REQ-029 SHALL cover: write 'h12345678 with sel=4'b0101 to reg 0 (prior 0), then commit_i -> regs_q_o[0]='h00340078 one cycle after commit; wr_pulse_o[0] pulses once.
REQ-030 SHALL cover: write to an RO register, to BASE+2, and to BASE+4*NREGS -> err each, no state change, no pulse.
REQ-031 SHALL cover: commit_i in the same cycle as a write 'hFF to reg 2 (shadow 'h11) -> active='h11; a second commit gives active='hFF.
REQ-032 SHALL cover: stb held for 6 cycles -> exactly 3 acks at cycles 1, 3 and 5.
REQ-033 SHALL cover: wb_rst_i asserted in the cycle after a request -> ack never asserts, and registers return to RESET_VAL.
